// File: rtl/cpu_wr_ctrl.sv
// Turns the asynchronous CPU write bus into single-cycle synchronous write strobes for a
// three-register bank. It also keeps saturating debug counts of glitches and unmapped writes.
module cpu_wr_ctrl #(
   parameter int                ADDR_W      = 4,
   parameter int                SYNC_STAGES = 2,
   parameter int                MIN_LOW     = 2,
   parameter logic [ADDR_W-1:0] REG1_ADDR   = 4'h1,
   parameter logic [ADDR_W-1:0] REG2_ADDR   = 4'h2,
   parameter logic [ADDR_W-1:0] REG3_ADDR   = 4'h3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              CS_,
   input  logic              WE_,
   input  logic [ADDR_W-1:0] addr,
   input  logic [7:0]        data,
   output logic [7:0]        data_in,
   output logic              my_wr,
   output logic              CS_reg1,
   output logic              CS_reg2,
   output logic              CS_reg3,
   output logic              wr_busy,
   output logic [7:0]        glitch_cnt,
   output logic [7:0]        bad_addr_cnt
);

   localparam int LW = $clog2(MIN_LOW + 1);

   localparam logic [2:0] S_WAIT_IDLE = 3'd0;
   localparam logic [2:0] S_IDLE      = 3'd1;
   localparam logic [2:0] S_ARM       = 3'd2;
   localparam logic [2:0] S_LOW       = 3'd3;
   localparam logic [2:0] S_COMMIT    = 3'd4;
   localparam logic [2:0] S_RECOVER   = 3'd5;

   logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
   logic [SYNC_STAGES-1:0] we_sync_q, we_sync_d;
   logic [2:0]             state_q, state_d;
   logic [LW-1:0]          lowcnt_q, lowcnt_d;
   logic [ADDR_W-1:0]      addr_q, addr_d;
   logic [7:0]             data_in_q, data_in_d;
   logic                   my_wr_q, my_wr_d;
   logic [2:0]             cs_reg_q, cs_reg_d;
   logic [7:0]             glitch_cnt_q, glitch_cnt_d;
   logic [7:0]             bad_addr_cnt_q, bad_addr_cnt_d;
   logic                   cs_s, we_s, wr_act;

   // Synchronizers shift toward the MSB; the MSB is the synchronized level.
   assign cs_sync_d = {cs_sync_q[SYNC_STAGES-2:0], CS_};
   assign we_sync_d = {we_sync_q[SYNC_STAGES-2:0], WE_};
   assign cs_s      = cs_sync_q[SYNC_STAGES-1];
   assign we_s      = we_sync_q[SYNC_STAGES-1];
   assign wr_act    = !cs_s && !we_s;

   always_comb begin
      state_d        = state_q;
      lowcnt_d       = lowcnt_q;
      addr_d         = addr_q;
      data_in_d      = data_in_q;
      my_wr_d        = 1'b0;
      cs_reg_d       = 3'b000;
      glitch_cnt_d   = glitch_cnt_q;
      bad_addr_cnt_d = bad_addr_cnt_q;
      case (state_q)
         S_WAIT_IDLE: begin
            if (!wr_act) state_d = S_IDLE;
         end
         S_IDLE: begin
            if (wr_act) begin
               state_d  = S_ARM;
               lowcnt_d = LW'(1);
            end
         end
         S_ARM: begin
            if (!wr_act) begin
               if (glitch_cnt_q != 8'hFF) glitch_cnt_d = glitch_cnt_q + 8'd1;
               state_d = S_IDLE;
            end else if (lowcnt_q == LW'(MIN_LOW)) begin
               state_d = S_LOW;
            end else begin
               lowcnt_d = lowcnt_q + LW'(1);
            end
         end
         S_LOW: begin
            if (wr_act) begin
               addr_d    = addr;
               data_in_d = data;
            end else begin
               // Decode now so the strobes are registered and land exactly in COMMIT.
               state_d = S_COMMIT;
               if (addr_q == REG1_ADDR)      cs_reg_d = 3'b001;
               else if (addr_q == REG2_ADDR) cs_reg_d = 3'b010;
               else if (addr_q == REG3_ADDR) cs_reg_d = 3'b100;
               else if (bad_addr_cnt_q != 8'hFF) bad_addr_cnt_d = bad_addr_cnt_q + 8'd1;
               my_wr_d = |cs_reg_d;
            end
         end
         S_COMMIT:  state_d = S_RECOVER;
         S_RECOVER: state_d = S_IDLE;
         default:   state_d = S_WAIT_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cs_sync_q      <= '1;
         we_sync_q      <= '1;
         state_q        <= S_WAIT_IDLE;
         lowcnt_q       <= '0;
         addr_q         <= '0;
         data_in_q      <= '0;
         my_wr_q        <= 1'b0;
         cs_reg_q       <= 3'b000;
         glitch_cnt_q   <= '0;
         bad_addr_cnt_q <= '0;
      end else begin
         cs_sync_q      <= cs_sync_d;
         we_sync_q      <= we_sync_d;
         state_q        <= state_d;
         lowcnt_q       <= lowcnt_d;
         addr_q         <= addr_d;
         data_in_q      <= data_in_d;
         my_wr_q        <= my_wr_d;
         cs_reg_q       <= cs_reg_d;
         glitch_cnt_q   <= glitch_cnt_d;
         bad_addr_cnt_q <= bad_addr_cnt_d;
      end
   end

   assign data_in      = data_in_q;
   assign my_wr        = my_wr_q;
   assign CS_reg1      = cs_reg_q[0];
   assign CS_reg2      = cs_reg_q[1];
   assign CS_reg3      = cs_reg_q[2];
   assign wr_busy      = (state_q != S_IDLE);
   assign glitch_cnt   = glitch_cnt_q;
   assign bad_addr_cnt = bad_addr_cnt_q;

endmodule

// File: tb/tb_cpu_wr_ctrl.sv
// Directed bench for cpu_wr_ctrl: CPU bus cycles are driven just after the rising edge,
// and every write strobe is logged at the falling edge for later comparison.
module tb_cpu_wr_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       CS_, WE_;
   logic [3:0] addr;
   logic [7:0] data;
   logic [7:0] data_in;
   logic       my_wr, CS_reg1, CS_reg2, CS_reg3, wr_busy;
   logic [7:0] glitch_cnt, bad_addr_cnt;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int t_rise = 0;

   int         q_cyc[$];
   logic [2:0] q_cs[$];
   logic [7:0] q_data[$];
   int         q_idle[$];
   int         idle_run = 0;
   int         stray = 0;

   cpu_wr_ctrl dut (
      .clk(clk), .rst(rst), .CS_(CS_), .WE_(WE_), .addr(addr), .data(data),
      .data_in(data_in), .my_wr(my_wr), .CS_reg1(CS_reg1), .CS_reg2(CS_reg2),
      .CS_reg3(CS_reg3), .wr_busy(wr_busy), .glitch_cnt(glitch_cnt),
      .bad_addr_cnt(bad_addr_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Strobe log: each my_wr pulse with its selects, data and idle cycles since the last pulse.
   always @(negedge clk) begin
      if (my_wr) begin
         q_cyc.push_back(cyc);
         q_cs.push_back({CS_reg3, CS_reg2, CS_reg1});
         q_data.push_back(data_in);
         q_idle.push_back(idle_run);
         idle_run = 0;
      end else if (CS_reg1 || CS_reg2 || CS_reg3) begin
         stray++;
      end
      if (!wr_busy) idle_run++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      q_cyc.delete();
      q_cs.delete();
      q_data.delete();
      q_idle.delete();
   endtask

   task automatic bus_write(input logic [3:0] a, input logic [7:0] d, input int n_low);
      CS_ = 1'b0; WE_ = 1'b0; addr = a; data = d;
      step(n_low);
      WE_ = 1'b1;
      t_rise = cyc;
      step(1);
      CS_ = 1'b1;
      step(12);
   endtask

   initial begin
      rst = 1'b0; CS_ = 1'b1; WE_ = 1'b1; addr = 4'h0; data = 8'h00;
      #1 rst = 1'b1;
      #1;
      check("rst_my_wr", my_wr, 1'b0);
      check("rst_cs", {CS_reg3, CS_reg2, CS_reg1}, 3'b000);
      check("rst_data_in", data_in, 8'h00);
      check("rst_wr_busy", wr_busy, 1'b1);
      check("rst_glitch", glitch_cnt, 8'h00);
      check("rst_bad", bad_addr_cnt, 8'h00);
      step(3);
      rst = 1'b0;
      step(4);
      check("idle_busy", wr_busy, 1'b0);

      // Write to reg2
      clear_log();
      bus_write(4'h2, 8'hA5, 6);
      check("w2_pulses", q_cyc.size(), 1);
      if (q_cyc.size() >= 1) begin
         check("w2_cs", q_cs[0], 3'b010);
         check("w2_data", q_data[0], 8'hA5);
         check("w2_latency", q_cyc[0] - t_rise, 3);
      end

      // One-clock glitch, then a valid write to reg1
      clear_log();
      CS_ = 1'b0; WE_ = 1'b0;
      step(1);
      WE_ = 1'b1;
      step(1);
      CS_ = 1'b1;
      step(8);
      check("glitch_pulses", q_cyc.size(), 0);
      check("glitch_cnt", glitch_cnt, 8'd1);
      clear_log();
      bus_write(4'h1, 8'h3C, 6);
      check("w1_pulses", q_cyc.size(), 1);
      if (q_cyc.size() >= 1) begin
         check("w1_cs", q_cs[0], 3'b001);
         check("w1_data", q_data[0], 8'h3C);
      end
      check("w1_data_hold", data_in, 8'h3C);

      // Unmapped writes and counter saturation
      clear_log();
      bus_write(4'hF, 8'h10, 6);
      check("bad_pulses", q_cyc.size(), 0);
      check("bad_cnt_1", bad_addr_cnt, 8'd1);
      for (int i = 1; i < 255; i++) bus_write(4'hF, i[7:0], 6);
      check("bad_cnt_255", bad_addr_cnt, 8'd255);
      for (int i = 255; i < 300; i++) bus_write(4'hF, i[7:0], 6);
      check("bad_cnt_sat", bad_addr_cnt, 8'd255);
      check("bad_no_pulse", q_cyc.size(), 0);
      check("glitch_kept", glitch_cnt, 8'd1);

      // CS_ released first; the later WE_ rise must not strobe again
      clear_log();
      CS_ = 1'b0; WE_ = 1'b0; addr = 4'h1; data = 8'h5A;
      step(6);
      CS_ = 1'b1;
      t_rise = cyc;
      step(10);
      WE_ = 1'b1;
      step(10);
      check("csrel_pulses", q_cyc.size(), 1);
      if (q_cyc.size() >= 1) begin
         check("csrel_cs", q_cs[0], 3'b001);
         check("csrel_data", q_data[0], 8'h5A);
         check("csrel_latency", q_cyc[0] - t_rise, 3);
      end

      // Back-to-back writes with two idle clocks between them
      clear_log();
      CS_ = 1'b0; WE_ = 1'b0; addr = 4'h1; data = 8'h11;
      step(6);
      CS_ = 1'b1; WE_ = 1'b1;
      step(2);
      CS_ = 1'b0; WE_ = 1'b0; addr = 4'h2; data = 8'h22;
      step(6);
      CS_ = 1'b1; WE_ = 1'b1;
      step(12);
      check("b2b_pulses", q_cyc.size(), 2);
      if (q_cyc.size() >= 2) begin
         check("b2b_cs0", q_cs[0], 3'b001);
         check("b2b_data0", q_data[0], 8'h11);
         check("b2b_cs1", q_cs[1], 3'b010);
         check("b2b_data1", q_data[1], 8'h22);
         check("b2b_idle_between", (q_idle[1] > 0), 1'b1);
      end

      // Reset in the middle of a held write
      clear_log();
      CS_ = 1'b0; WE_ = 1'b0; addr = 4'hF; data = 8'h77;
      step(8);
      rst = 1'b1;
      #1;
      check("mid_rst_my_wr", my_wr, 1'b0);
      check("mid_rst_busy", wr_busy, 1'b1);
      check("mid_rst_data_in", data_in, 8'h00);
      check("mid_rst_glitch", glitch_cnt, 8'h00);
      check("mid_rst_bad", bad_addr_cnt, 8'h00);
      step(2);
      rst = 1'b0;
      step(6);
      check("mid_rst_held_pulses", q_cyc.size(), 0);
      CS_ = 1'b1; WE_ = 1'b1;
      step(12);
      check("mid_rst_idle_pulses", q_cyc.size(), 0);
      clear_log();
      bus_write(4'h3, 8'hC3, 6);
      check("w3_pulses", q_cyc.size(), 1);
      if (q_cyc.size() >= 1) begin
         check("w3_cs", q_cs[0], 3'b100);
         check("w3_data", q_data[0], 8'hC3);
      end

      check("stray_selects", stray, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
